// File: rtl/gvc_pkg.sv
// Shared types and sizing helpers for the gate vector checker.
// Provides the FSM state encoding and width helpers used by the checker and its settle timer.
package gvc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } gvc_state_t;

    localparam int unsigned GVC_STATE_W  = 2;
    localparam int unsigned GVC_MAX_N_IN = 16;

    function automatic int unsigned gvc_nvec(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    function automatic int unsigned gvc_tbl_w(input int unsigned n_in, input int unsigned n_out);
        return n_out * (32'd1 << n_in);
    endfunction

    // Bits needed to hold the values 0..n (at least one bit).
    function automatic int unsigned gvc_cnt_w(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) <= n) w++;
        return w;
    endfunction

endpackage

// File: rtl/gvc_if.sv
// Gate-side bus of the checker: stimulus towards the gate, response back from it.
// The checker drives through the master modport; the gate model sits on the slave side.
interface gvc_gate_if #(
    parameter int N_IN  = 1,
    parameter int N_OUT = 1
);
    logic [N_IN-1:0]  dut_in;
    logic [N_OUT-1:0] dut_out;

    modport master (output dut_in, input dut_out);
    modport slave  (input dut_in, output dut_out);
endinterface

// File: rtl/gvc_settle_timer.sv
// Loadable down counter that times the settle window of each vector.
// expire is high while the count sits at zero; ticks at zero are ignored.
module gvc_settle_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive sweep/compare harness around a gate under test: drives every input vector, samples after a settle window.
// Optional build macro GVC_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module gate_vector_checker
    import gvc_pkg::*;
#(
    parameter int N_IN       = 1,
    parameter int N_OUT      = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [N_OUT*(2**N_IN)-1:0]  truth_tbl,
    gvc_gate_if.master                  gate,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [N_IN:0]               err_cnt,
    output logic                        fail_valid,
    output logic [N_IN-1:0]             fail_vec
);

    localparam int unsigned NVEC  = gvc_nvec(N_IN);
    localparam int unsigned VEC_W = N_IN + 1;
    localparam int unsigned TMR_W = gvc_cnt_w(SETTLE_CYC - 1);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NVEC - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE_CYC - 1);

    gvc_state_t        state, state_nxt;
    logic [VEC_W-1:0]  vec;
    logic [N_IN-1:0]   dut_in_r;
    logic [N_OUT-1:0]  exp_out;
    logic [N_IN:0]     err_cnt_nxt;
    logic              mismatch, last_vec, stop_hit;
    logic              run_start, do_sample, advance, finish;
    logic              tmr_load, tmr_tick, tmr_expire;

    gvc_settle_timer #(
        .CNT_W (TMR_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (TMR_LOAD),
        .tick     (tmr_tick),
        .expire   (tmr_expire)
    );

    assign gate.dut_in = dut_in_r;

    // Case-equality compare so an X or Z from the gate always counts as a failure.
    assign exp_out     = truth_tbl[vec[N_IN-1:0]*N_OUT +: N_OUT];
    assign mismatch    = (gate.dut_out !== exp_out);
    assign last_vec    = (vec == LAST_VEC);
    assign err_cnt_nxt = err_cnt + {{N_IN{1'b0}}, mismatch};

`ifdef GVC_STOP_ON_FAIL_EN
    assign stop_hit = mismatch;
`else
    assign stop_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        do_sample = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        tmr_load  = 1'b0;
        tmr_tick  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    run_start = 1'b1;
                    tmr_load  = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                tmr_tick = 1'b1;
                if (tmr_expire) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                do_sample = 1'b1;
                if (last_vec || stop_hit) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    advance   = 1'b1;
                    tmr_load  = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Vector counter, result capture and status; start is only honoured from IDLE/DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec        <= '0;
            dut_in_r   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            if (run_start) begin
                vec        <= '0;
                dut_in_r   <= '0;
                busy       <= 1'b1;
                done       <= 1'b0;
                pass       <= 1'b0;
                err_cnt    <= '0;
                fail_valid <= 1'b0;
                fail_vec   <= '0;
            end
            if (do_sample && mismatch) begin
                err_cnt <= err_cnt_nxt;
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_vec   <= vec[N_IN-1:0];
                end
            end
            if (advance) begin
                vec      <= vec + 1'b1;
                dut_in_r <= vec[N_IN-1:0] + 1'b1;
            end
            if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_cnt_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: a NOT/Z gate on a 1-input checker and a NAND on a 2-input checker.
// Expected run results come from a behavioural sweep model pushed to a scoreboard queue at each start.
module tb_gate_vector_checker;

    localparam int S = 2;

    typedef struct {
        int err;
        int fvalid;
        int fvec;
        int pass;
        int lat;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n, start1, start2, zmode, zval;
    logic [1:0]  tbl1;
    logic [3:0]  tbl2;
    logic        busy1, done1, pass1, fv1;
    logic [1:0]  err1;
    logic [0:0]  fvec1;
    logic        busy2, done2, pass2, fv2;
    logic [2:0]  err2;
    logic [1:0]  fvec2;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t exp_q[$];
    int   vec_q[$];

    always #5 clk = ~clk;

    gvc_gate_if #(.N_IN(1), .N_OUT(1)) g1 ();
    gvc_gate_if #(.N_IN(2), .N_OUT(1)) g2 ();

    assign g1.dut_out = zmode ? zval : ~g1.dut_in;
    assign g2.dut_out = ~(g2.dut_in[0] & g2.dut_in[1]);

    gate_vector_checker #(.N_IN(1), .N_OUT(1), .SETTLE_CYC(S)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .truth_tbl(tbl1), .gate(g1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .fail_valid(fv1), .fail_vec(fvec1)
    );

    gate_vector_checker #(.N_IN(2), .N_OUT(1), .SETTLE_CYC(S)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .truth_tbl(tbl2), .gate(g2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .fail_valid(fv2), .fail_vec(fvec2)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // f: 0 busy, 1 done, 2 pass, 3 err_cnt, 4 fail_valid, 5 fail_vec, 6 dut_in
    function automatic logic [31:0] ob(input int sel, input int f);
        logic [31:0] r;
        r = '0;
        if (sel == 2) begin
            case (f)
                0: r = 32'(busy2);
                1: r = 32'(done2);
                2: r = 32'(pass2);
                3: r = 32'(err2);
                4: r = 32'(fv2);
                5: r = 32'(fvec2);
                default: r = 32'(g2.dut_in);
            endcase
        end else begin
            case (f)
                0: r = 32'(busy1);
                1: r = 32'(done1);
                2: r = 32'(pass1);
                3: r = 32'(err1);
                4: r = 32'(fv1);
                5: r = 32'(fvec1);
                default: r = 32'(g1.dut_in);
            endcase
        end
        return r;
    endfunction

    // kind: 0 = NOT gate, 1 = undriven output, 2 = NAND gate
    function automatic res_t model(input int nin, input logic [3:0] tbl, input int kind);
        res_t r;
        bit   stop;
        logic g;
        r    = '{0, 0, 0, 0, (1 << nin) * (S + 1)};
        stop = 1'b0;
        for (int v = 0; v < (1 << nin); v++) begin
            if (!stop) begin
                case (kind)
                    0:       g = ~v[0];
                    1:       g = zval;
                    default: g = ~(v[0] & v[1]);
                endcase
                if (g !== tbl[v]) begin
                    r.err++;
                    if (r.fvalid == 0) begin
                        r.fvalid = 1;
                        r.fvec   = v;
                    end
`ifdef GVC_STOP_ON_FAIL_EN
                    stop  = 1'b1;
                    r.lat = (v + 1) * (S + 1);
`endif
                end
            end
        end
        r.pass = (r.err == 0) ? 1 : 0;
        return r;
    endfunction

    task automatic set_start(input int sel, input logic val);
        if (sel == 2) start2 = val;
        else          start1 = val;
    endtask

    // Starts a run on the selected checker, optionally re-pulses start at cycle inj, then scores the result.
    task automatic run(input string tag, input int sel, input int kind, input int inj);
        res_t e;
        int   c;
        bit   ok;
        exp_q.push_back(model(sel == 2 ? 2 : 1, (sel == 2) ? tbl2 : {2'b00, tbl1}, kind));
        if (sel == 2) for (int v = 0; v < 4; v++) vec_q.push_back(v);
        set_start(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(sel, 1'b0);
        c  = 0;
        ok = 1'b0;
        while (c < 200) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            set_start(sel, 1'b0);
            if (sel == 2 && ((c - 1) % (S + 1)) == 0 && vec_q.size() > 0)
                chk({tag, ".dut_in_seq"}, ob(sel, 6), 32'(vec_q.pop_front()));
            if (ob(sel, 1) == 1) begin
                ok = 1'b1;
                break;
            end
            if (c == inj) set_start(sel, 1'b1);
        end
        vec_q.delete();
        chk({tag, ".done_reached"}, 32'(ok), 1);
        e = exp_q.pop_front();
        chk({tag, ".latency"}, 32'(c), 32'(e.lat));
        chk({tag, ".busy"}, ob(sel, 0), 0);
        chk({tag, ".pass"}, ob(sel, 2), 32'(e.pass));
        chk({tag, ".err_cnt"}, ob(sel, 3), 32'(e.err));
        chk({tag, ".fail_valid"}, ob(sel, 4), 32'(e.fvalid));
        chk({tag, ".fail_vec"}, ob(sel, 5), 32'(e.fvec));
    endtask

    task automatic chk_all_zero(input string tag);
        for (int s = 1; s <= 2; s++)
            for (int f = 0; f < 7; f++)
                chk($sformatf("%s.u%0d.f%0d", tag, s, f), ob(s, f), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        zmode  = 1'b0;
        zval   = 1'bz;
        tbl1   = 2'b01;
        tbl2   = 4'b0111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        tbl1 = 2'b01;
        run("not_pass", 1, 0, 0);

        tbl1 = 2'b10;
        run("not_fail", 1, 0, 0);
        run("not_fail_rerun", 1, 0, 0);

        tbl1 = 2'b01;
        run("start_while_busy", 1, 0, 2);

        zmode = 1'b1;
        run("undriven_out", 1, 1, 0);
        zmode = 1'b0;

        // Abort during the vector-1 settle window, with start held alongside reset.
        tbl1   = 2'b01;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort.busy_before", ob(1, 0), 1);
        chk("abort.dut_in_before", ob(1, 6), 1);
        rst_n  = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("abort");
        rst_n  = 1'b1;
        start1 = 1'b0;
        run("after_abort", 1, 0, 0);

        tbl2 = 4'b0111;
        run("nand_pass", 2, 2, 0);
        chk("nand_pass.dut_in_last", ob(2, 6), 3);
        tbl2 = 4'b1110;
        run("nand_fail", 2, 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
